// File: rtl/ftdi_pkg.sv
// ftdi_pkg: shared types and default widths for the FT600/FT601 loopback bridge.
//   state_t      loopback FSM state encoding (IDLE must be zero so oTP resets to 0)
//   *_DEF        default data, byte-enable and FIFO address widths (FT601 build)
package ftdi_pkg;

  localparam int D_BIT_DEF   = 32;
  localparam int BE_BIT_DEF  = D_BIT_DEF / 8;
  localparam int FIFO_AW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_OE  = 3'd1,
    RD     = 3'd2,
    RD_END = 3'd3,
    WR     = 3'd4,
    WR_END = 3'd5
  } state_t;

endpackage

// File: rtl/ftdi_lb_fifo.sv
// ftdi_lb_fifo: single-clock loopback FIFO, 2**AW words of W bits.
//   clk, rst     clock, asynchronous active-high reset (empties the FIFO)
//   push, din    write request and word; ignored while full
//   pop          read request; ignored while empty
//   head         word at the read pointer (valid while not empty)
//   full, empty  occupancy flags
//   count        number of stored words (0 .. 2**AW)
module ftdi_lb_fifo
  import ftdi_pkg::*;
#(
  parameter int W  = D_BIT_DEF + BE_BIT_DEF,
  parameter int AW = FIFO_AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0] mem [2**AW];
  // One extra pointer bit separates the full and empty cases when the
  // address bits coincide.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ftdi_loopback_top.sv
// ftdi_loopback_top: FPGA side of an FT600/FT601 245-synchronous-FIFO bridge.
// Reads host bursts into a FIFO and writes them back unchanged.
//   iCLK     FTDI clock, sole clock          iRESET  async active-high reset
//   ioDATA   FTDI data bus (inout)           ioBE    byte enables (inout, 1 = valid)
//   iTXE_N   0 = FTDI may accept a write     iRXF_N  0 = FTDI has data to read
//   oOE_N    0 = FTDI drives the bus         oRD_N   read strobe, oWR_N write strobe
//   oLED     [0] FIFO non-empty, [1] sticky overflow
//   oTP      {state, word accepted last cycle}
//
// state  | meaning
// IDLE   | bus released, choose read (priority) or write
// RD_OE  | OE_N low one cycle, FTDI takes the bus
// RD     | OE_N/RD_N low, capture a word on every cycle RXF_N is low
// RD_END | OE_N/RD_N high, turnaround before anything else
// WR     | WR_N low, FIFO head driven, pop on every cycle TXE_N is low
// WR_END | WR_N high, bus released
module ftdi_loopback_top
  import ftdi_pkg::*;
#(
  parameter int D_BIT   = D_BIT_DEF,
  parameter int BE_BIT  = D_BIT / 8,
  parameter int FIFO_AW = FIFO_AW_DEF
) (
  input  logic              iCLK,
  input  logic              iRESET,
  inout  wire  [D_BIT-1:0]  ioDATA,
  inout  wire  [BE_BIT-1:0] ioBE,
  input  logic              iTXE_N,
  input  logic              iRXF_N,
  output logic              oOE_N,
  output logic              oRD_N,
  output logic              oWR_N,
  output logic [1:0]        oLED,
  output logic [3:0]        oTP
);

  localparam int W = D_BIT + BE_BIT;
  localparam logic [FIFO_AW:0] LVL_ONE     = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0] LVL_FULL_M1 = (FIFO_AW+1)'(2**FIFO_AW - 1);

  state_t           state;
  logic             bus_drive;
  logic             overflow;
  logic             led_ne;
  logic             push;
  logic             pop;
  logic [W-1:0]     head;
  logic             full;
  logic             empty;
  logic [FIFO_AW:0] count;

  assign push = (state == RD) && !oRD_N && !iRXF_N;
  assign pop  = (state == WR) && !oWR_N && !iTXE_N;

  ftdi_lb_fifo #(.W(W), .AW(FIFO_AW)) u_fifo (
    .clk   (iCLK),
    .rst   (iRESET),
    .push  (push),
    .din   ({ioBE, ioDATA}),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign ioDATA = bus_drive ? head[D_BIT-1:0]  : {D_BIT{1'bz}};
  assign ioBE   = bus_drive ? head[W-1:D_BIT]  : {BE_BIT{1'bz}};
  assign oLED   = {overflow, led_ne};

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state     <= IDLE;
      oOE_N     <= 1'b1;
      oRD_N     <= 1'b1;
      oWR_N     <= 1'b1;
      bus_drive <= 1'b0;
      overflow  <= 1'b0;
      led_ne    <= 1'b0;
      oTP       <= 4'h0;
    end else begin
      oTP    <= {state, push | pop};
      led_ne <= !empty;
      if (push && full) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (!iRXF_N && !full) begin
            state <= RD_OE;
            oOE_N <= 1'b0;
          end else if (!iTXE_N && !empty) begin
            state     <= WR;
            oWR_N     <= 1'b0;
            bus_drive <= 1'b1;
          end
        end
        RD_OE: begin
          state <= RD;
          oRD_N <= 1'b0;
        end
        RD: begin
          // Leave on the push that fills the FIFO, so RD_N is already high
          // when full would otherwise let the next offered word be strobed.
          if (iRXF_N || full || (push && count == LVL_FULL_M1)) begin
            state <= RD_END;
            oOE_N <= 1'b1;
            oRD_N <= 1'b1;
          end
        end
        RD_END: state <= IDLE;
        WR: begin
          // A refused word stays at the head and is re-sent on the next burst.
          if (iTXE_N || count == LVL_ONE) begin
            state     <= WR_END;
            oWR_N     <= 1'b1;
            bus_drive <= 1'b0;
          end
        end
        WR_END: state <= IDLE;
        default: begin
          state     <= IDLE;
          oOE_N     <= 1'b1;
          oRD_N     <= 1'b1;
          oWR_N     <= 1'b1;
          bus_drive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi_loopback_top.sv
module tb_ftdi_loopback_top;

  logic        iCLK = 1'b0;
  logic        iRESET;
  wire  [31:0] ioDATA;
  wire  [3:0]  ioBE;
  logic        iTXE_N;
  logic        iRXF_N;
  logic        oOE_N, oRD_N, oWR_N;
  logic [1:0]  oLED;
  logic [3:0]  oTP;

  always #5 iCLK = ~iCLK;

  ftdi_loopback_top dut (
    .iCLK(iCLK), .iRESET(iRESET), .ioDATA(ioDATA), .ioBE(ioBE),
    .iTXE_N(iTXE_N), .iRXF_N(iRXF_N), .oOE_N(oOE_N), .oRD_N(oRD_N),
    .oWR_N(oWR_N), .oLED(oLED), .oTP(oTP)
  );

  // host (FTDI chip) model
  logic [31:0] host_word = '0;
  logic [3:0]  host_be   = '0;
  assign ioDATA = !oOE_N ? host_word : 32'hzzzz_zzzz;
  assign ioBE   = !oOE_N ? host_be   : 4'hz;

  logic [35:0] rx_q[$];
  logic [35:0] exp_q[$];
  int          tests = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [3:0]  last_be = '0;
  logic        rd_hs = 1'b0, wr_hs = 1'b0, wr_oe = 1'b1;
  logic [35:0] wr_word = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge iCLK) begin
    rd_hs   <= !oRD_N && !iRXF_N && !iRESET;
    wr_hs   <= !oWR_N && !iTXE_N && !iRESET;
    wr_word <= {ioBE, ioDATA};
    wr_oe   <= oOE_N;
  end

  always @(negedge iCLK) begin
    if (rd_hs) begin
      if (rx_q.size() > 0) begin
        exp_q.push_back(rx_q[0]);
        void'(rx_q.pop_front());
      end
      rd_cnt++;
    end
    if (wr_hs) begin
      check("wr_oe_high", {63'b0, wr_oe}, 64'd1);
      check("wr_no_x", {63'b0, $isunknown(wr_word)}, 64'd0);
      if (exp_q.size() > 0) check("wr_word", wr_word, exp_q.pop_front());
      else check("wr_unexpected", 64'(exp_q.size()), 64'd1);
      last_be = wr_word[35:32];
      wr_cnt++;
    end
    if (rx_q.size() > 0) begin
      host_word = rx_q[0][31:0];
      host_be   = rx_q[0][35:32];
      iRXF_N    = 1'b0;
    end else begin
      iRXF_N = 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(negedge iCLK); #1; end
  endtask

  task automatic wait_cnt(input string tag, input bit sel_wr, input int target, input int max_cyc);
    int n = 0;
    while (((sel_wr ? wr_cnt : rd_cnt) < target) && n < max_cyc) begin
      @(negedge iCLK); #1; n++;
    end
    check(tag, 64'(sel_wr ? wr_cnt : rd_cnt), 64'(target));
  endtask

  initial begin
    logic [31:0] zd;
    logic [3:0]  zb;
    int rb, wb, n;
    zd = 'z;
    zb = 'z;
    iRESET = 1'b1;
    iTXE_N = 1'b1;
    iRXF_N = 1'b1;
    #1;
    check("rst_ctl", {61'b0, oOE_N, oRD_N, oWR_N}, 64'd7);
    check("rst_data", {32'b0, ioDATA}, {32'b0, zd});
    check("rst_be", {60'b0, ioBE}, {60'b0, zb});
    check("rst_led", {62'b0, oLED}, 64'd0);
    check("rst_tp", {60'b0, oTP}, 64'd0);
    idle(2);
    iRESET = 1'b0;
    idle(2);

    // 4-word read then write-back
    rb = rd_cnt; wb = wr_cnt;
    for (int i = 1; i <= 4; i++) rx_q.push_back({4'hF, {8{4'(i)}}});
    wait_cnt("a_rd4", 1'b0, rb + 4, 50);
    idle(3);
    check("a_led_ne", {62'b0, oLED}, 64'd1);
    check("a_no_wr", 64'(wr_cnt), 64'(wb));
    iTXE_N = 1'b0;
    wait_cnt("a_wr4", 1'b1, wb + 4, 50);
    idle(5);
    check("a_wr_exact", 64'(wr_cnt), 64'(wb + 4));
    check("a_sb_empty", 64'(exp_q.size()), 64'd0);
    check("a_led_empty", {62'b0, oLED}, 64'd0);

    // TXE_N rises while word 2 is on the bus
    iTXE_N = 1'b1;
    rb = rd_cnt; wb = wr_cnt;
    for (int i = 0; i < 4; i++) rx_q.push_back({4'hF, 32'hA0A0_0000 + 32'(i)});
    wait_cnt("b_rd4", 1'b0, rb + 4, 50);
    idle(2);
    iTXE_N = 1'b0;
    wait_cnt("b_wr1", 1'b1, wb + 1, 50);
    iTXE_N = 1'b1;
    idle(6);
    check("b_hold", 64'(wr_cnt), 64'(wb + 1));
    iTXE_N = 1'b0;
    wait_cnt("b_wr4", 1'b1, wb + 4, 50);
    idle(5);
    check("b_wr_exact", 64'(wr_cnt), 64'(wb + 4));
    check("b_sb_empty", 64'(exp_q.size()), 64'd0);

    // partial final word
    iTXE_N = 1'b1;
    rb = rd_cnt; wb = wr_cnt;
    rx_q.push_back({4'hF, 32'hCAFE_0001});
    rx_q.push_back({4'hF, 32'hCAFE_0002});
    rx_q.push_back({4'h3, 32'h0000_BEEF});
    wait_cnt("c_rd3", 1'b0, rb + 3, 50);
    idle(2);
    iTXE_N = 1'b0;
    wait_cnt("c_wr3", 1'b1, wb + 3, 50);
    idle(3);
    check("c_last_be", {60'b0, last_be}, 64'h3);

    // 257 words offered into a 256-word FIFO
    iTXE_N = 1'b1;
    rb = rd_cnt; wb = wr_cnt;
    for (int i = 0; i < 257; i++) rx_q.push_back({4'hF, $urandom});
    wait_cnt("d_rd256", 1'b0, rb + 256, 600);
    idle(10);
    check("d_rd_exact", 64'(rd_cnt), 64'(rb + 256));
    check("d_left1", 64'(rx_q.size()), 64'd1);
    check("d_rd_n", {63'b0, oRD_N}, 64'd1);
    check("d_led", {62'b0, oLED}, 64'd1);
    force dut.push = 1'b1;
    @(negedge iCLK); #1;
    release dut.push;
    idle(1);
    check("d_ovf", {62'b0, oLED}, 64'd3);
    rx_q.delete();
    iTXE_N = 1'b0;
    wait_cnt("d_wr256", 1'b1, wb + 256, 600);
    idle(5);
    check("d_sb_empty", 64'(exp_q.size()), 64'd0);
    check("d_ovf_sticky", {62'b0, oLED}, 64'd2);
    iRESET = 1'b1;
    idle(2);
    iRESET = 1'b0;
    idle(2);
    check("d_ovf_clr", {62'b0, oLED}, 64'd0);

    // read wins when RXF_N and TXE_N are both low
    iTXE_N = 1'b1;
    rb = rd_cnt; wb = wr_cnt;
    rx_q.push_back({4'hF, 32'h5555_0001});
    rx_q.push_back({4'hF, 32'h5555_0002});
    wait_cnt("e_rd2", 1'b0, rb + 2, 50);
    idle(3);
    rx_q.push_back({4'hF, 32'h6666_0003});
    rx_q.push_back({4'hC, 32'h6666_0004});
    @(negedge iCLK); #1;
    iTXE_N = 1'b0;
    n = 0;
    while (rd_cnt == rb + 2 && wr_cnt == wb && n < 50) begin
      @(negedge iCLK); #1; n++;
    end
    check("e_rd_first", 64'(wr_cnt), 64'(wb));
    check("e_rd_started", 64'(rd_cnt), 64'(rb + 3));
    wait_cnt("e_wr4", 1'b1, wb + 4, 60);
    idle(5);
    check("e_sb_empty", 64'(exp_q.size()), 64'd0);

    // reset in the middle of a read burst
    iTXE_N = 1'b1;
    rb = rd_cnt; wb = wr_cnt;
    for (int i = 0; i < 6; i++) rx_q.push_back({4'hF, 32'h7777_0000 + 32'(i)});
    wait_cnt("f_rd2", 1'b0, rb + 2, 50);
    check("f_mid_rd", {63'b0, oRD_N}, 64'd0);
    #2 iRESET = 1'b1;
    #1;
    check("f_rst_ctl", {61'b0, oOE_N, oRD_N, oWR_N}, 64'd7);
    check("f_rst_data", {32'b0, ioDATA}, {32'b0, zd});
    check("f_rst_led", {62'b0, oLED}, 64'd0);
    @(negedge iCLK); #1;
    rx_q.delete();
    exp_q.delete();
    iRESET = 1'b0;
    idle(4);
    check("f_idle_ctl", {61'b0, oOE_N, oRD_N, oWR_N}, 64'd7);
    wb = wr_cnt;
    rx_q.push_back({4'h1, 32'h0000_00AB});
    iTXE_N = 1'b0;
    wait_cnt("f_recover", 1'b1, wb + 1, 50);
    idle(3);
    check("f_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
